// File: rtl/id_ex_issue_if.sv
// Signal bundle between the decode stage and the ID/EX issue register.
// The master side is decode; the slave side is the issue register that feeds the ALU.
interface id_ex_issue_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          stall;
  logic          flush;
  logic          id_valid;
  logic [DW-1:0] id_rd1;
  logic [DW-1:0] id_rd2;
  logic [DW-1:0] id_imm;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic [1:0]    id_alu_op;
  logic [5:0]    id_funct;
  logic          id_alu_src;
  logic          id_reg_dst;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          id_mem_to_reg;

  logic          ex_valid;
  logic [DW-1:0] ex_A;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic          ex_sel;
  logic [2:0]    ex_control;
  logic [RW-1:0] ex_write_reg;
  logic [RW-1:0] ex_rs;
  logic [RW-1:0] ex_rt;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_mem_to_reg;
  logic          ex_illegal;
  logic          load_use_stall;

  modport master (
    output stall, flush, id_valid, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
           id_alu_op, id_funct, id_alu_src, id_reg_dst, id_reg_write,
           id_mem_read, id_mem_write, id_mem_to_reg,
    input  ex_valid, ex_A, ex_a, ex_b, ex_sel, ex_control, ex_write_reg,
           ex_rs, ex_rt, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, ex_illegal, load_use_stall
  );

  modport slave (
    input  stall, flush, id_valid, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
           id_alu_op, id_funct, id_alu_src, id_reg_dst, id_reg_write,
           id_mem_read, id_mem_write, id_mem_to_reg,
    output ex_valid, ex_A, ex_a, ex_b, ex_sel, ex_control, ex_write_reg,
           ex_rs, ex_rt, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, ex_illegal, load_use_stall
  );
endinterface

// File: rtl/id_ex_issue.sv
// ID/EX pipeline register: latches decode operands/controls, decodes ALU control,
// and inserts bubbles for flush and load-use hazards.
module id_ex_issue #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic         clk,
  input  logic         reset,
  id_ex_issue_if.slave bus
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] op_a;
    logic [DW-1:0] mux_a;
    logic [DW-1:0] mux_b;
    logic          sel;
    logic [2:0]    control;
    logic [RW-1:0] write_reg;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          illegal;
  } ex_t;

  ex_t        ex_q;
  ex_t        ex_d;
  ex_t        id_load;
  logic [2:0] ctrl_dec;
  logic       illegal_dec;
  logic       load_use;

  always_comb begin
    ctrl_dec    = 3'b010;
    illegal_dec = 1'b0;
    case (bus.id_alu_op)
      2'b00: ctrl_dec = 3'b010;
      2'b01: ctrl_dec = 3'b110;
      2'b11: ctrl_dec = 3'b001;
      default: begin
        case (bus.id_funct)
          6'b100000: ctrl_dec = 3'b010;
          6'b100010: ctrl_dec = 3'b110;
          6'b100100: ctrl_dec = 3'b000;
          6'b100101: ctrl_dec = 3'b001;
          6'b101010: ctrl_dec = 3'b111;
          default:   illegal_dec = 1'b1;
        endcase
      end
    endcase
  end

  // An invalid decode slot loads exactly like a bubble.
  always_comb begin
    id_load = '0;
    if (bus.id_valid) begin
      id_load.valid      = 1'b1;
      id_load.op_a       = bus.id_rd1;
      id_load.mux_a      = bus.id_rd2;
      id_load.mux_b      = bus.id_imm;
      id_load.sel        = bus.id_alu_src;
      id_load.control    = ctrl_dec;
      id_load.write_reg  = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      id_load.rs         = bus.id_rs;
      id_load.rt         = bus.id_rt;
      id_load.reg_write  = bus.id_reg_write;
      id_load.mem_read   = bus.id_mem_read;
      id_load.mem_write  = bus.id_mem_write;
      id_load.mem_to_reg = bus.id_mem_to_reg;
      id_load.illegal    = illegal_dec;
    end
  end

  assign load_use = ~reset & ex_q.valid & ex_q.mem_read & bus.id_valid &
                    (ex_q.rt != '0) &
                    ((ex_q.rt == bus.id_rs) | (ex_q.rt == bus.id_rt));

  // Flush outranks stall so a squashed instruction never lingers in EX.
  always_comb begin
    ex_d = ex_q;
    if (bus.flush)      ex_d = '0;
    else if (bus.stall) ex_d = ex_q;
    else if (load_use)  ex_d = '0;
    else                ex_d = id_load;
  end

  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign bus.ex_valid       = ex_q.valid;
  assign bus.ex_A           = ex_q.op_a;
  assign bus.ex_a           = ex_q.mux_a;
  assign bus.ex_b           = ex_q.mux_b;
  assign bus.ex_sel         = ex_q.sel;
  assign bus.ex_control     = ex_q.control;
  assign bus.ex_write_reg   = ex_q.write_reg;
  assign bus.ex_rs          = ex_q.rs;
  assign bus.ex_rt          = ex_q.rt;
  assign bus.ex_reg_write   = ex_q.reg_write;
  assign bus.ex_mem_read    = ex_q.mem_read;
  assign bus.ex_mem_write   = ex_q.mem_write;
  assign bus.ex_mem_to_reg  = ex_q.mem_to_reg;
  assign bus.ex_illegal     = ex_q.illegal;
  assign bus.load_use_stall = load_use;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed bench for id_ex_issue: reset, ALU-control decode, operand pass-through,
// load-use bubbles, stall/flush interaction and reset during a hazard.
module tb_id_ex_issue;
  localparam int DW = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_issue_if #(.DW(DW), .RW(RW)) bus();
  id_ex_issue #(.DW(DW), .RW(RW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic src, input logic dst, input logic rw,
                       input logic mr, input logic mw, input logic m2r);
    bus.id_valid      = v;
    bus.id_alu_op     = op;
    bus.id_funct      = fn;
    bus.id_rs         = rs;
    bus.id_rt         = rt;
    bus.id_rd         = rd;
    bus.id_alu_src    = src;
    bus.id_reg_dst    = dst;
    bus.id_reg_write  = rw;
    bus.id_mem_read   = mr;
    bus.id_mem_write  = mw;
    bus.id_mem_to_reg = m2r;
  endtask

  task automatic data(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
    bus.id_rd1 = r1;
    bus.id_rd2 = r2;
    bus.id_imm = im;
  endtask

  logic [1:0] sw_op   [9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
  logic [5:0] sw_fn   [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h3F, 6'h2A, 6'h22};
  logic [2:0] sw_ctrl [9] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010, 3'b010, 3'b110, 3'b001};
  logic       sw_ill  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    // Reset with every decode input driven high.
    reset     = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b1, 2'b11, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    data(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    tick();
    check("rst_valid",    32'(bus.ex_valid), 32'd0);
    check("rst_control",  32'(bus.ex_control), 32'd0);
    check("rst_A",        bus.ex_A, 32'd0);
    check("rst_b",        bus.ex_b, 32'd0);
    check("rst_wreg",     32'(bus.ex_write_reg), 32'd0);
    check("rst_memrd",    32'(bus.ex_mem_read), 32'd0);
    check("rst_lu",       32'(bus.load_use_stall), 32'd0);

    // Operand pass-through, first load after reset release.
    reset = 1'b0;
    drive(1'b1, 2'b00, 6'h00, 5'd3, 5'd9, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    data(32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0010);
    check("pre_load_valid", 32'(bus.ex_valid), 32'd0);
    tick();
    check("op_valid",   32'(bus.ex_valid), 32'd1);
    check("op_A",       bus.ex_A, 32'h0000_0005);
    check("op_a",       bus.ex_a, 32'hFFFF_FFFF);
    check("op_b",       bus.ex_b, 32'h0000_0010);
    check("op_sel",     32'(bus.ex_sel), 32'd1);
    check("op_wreg",    32'(bus.ex_write_reg), 32'd9);
    check("op_rs",      32'(bus.ex_rs), 32'd3);
    check("op_rt",      32'(bus.ex_rt), 32'd9);
    check("op_control", 32'(bus.ex_control), 32'b010);
    check("op_regwr",   32'(bus.ex_reg_write), 32'd1);

    // ALU control decode sweep; reg_dst=1 so write_reg follows rd.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, sw_op[i], sw_fn[i], 5'd1, 5'd2, 5'(i + 20), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check($sformatf("dec%0d_ctrl", i), 32'(bus.ex_control), 32'(sw_ctrl[i]));
      check($sformatf("dec%0d_ill", i),  32'(bus.ex_illegal), 32'(sw_ill[i]));
    end
    check("dec_wreg_rd", 32'(bus.ex_write_reg), 32'd28);

    // Invalid decode slot loads as a bubble.
    drive(1'b0, 2'b10, 6'h27, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    check("inv_valid", 32'(bus.ex_valid), 32'd0);
    check("inv_ill",   32'(bus.ex_illegal), 32'd0);
    check("inv_A",     bus.ex_A, 32'd0);

    // Load-use: lw rt=8, then add with rs=8.
    drive(1'b1, 2'b00, 6'h00, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    data(32'h100, 32'h200, 32'h4);
    tick();
    check("lw_memrd", 32'(bus.ex_mem_read), 32'd1);
    drive(1'b1, 2'b10, 6'h20, 5'd8, 5'd4, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    data(32'h11, 32'h22, 32'h0);
    #1;
    check("lu_assert", 32'(bus.load_use_stall), 32'd1);
    tick();
    check("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
    check("lu_bubble_ctrl",  32'(bus.ex_control), 32'd0);
    check("lu_bubble_A",     bus.ex_A, 32'd0);
    check("lu_deassert",     32'(bus.load_use_stall), 32'd0);
    tick();
    check("lu_add_valid", 32'(bus.ex_valid), 32'd1);
    check("lu_add_wreg",  32'(bus.ex_write_reg), 32'd10);
    check("lu_add_A",     bus.ex_A, 32'h11);

    // Load into $zero never stalls.
    drive(1'b1, 2'b00, 6'h00, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 2'b10, 6'h22, 5'd0, 5'd0, 5'd11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("lu_zero", 32'(bus.load_use_stall), 32'd0);
    tick();
    check("lu_zero_valid", 32'(bus.ex_valid), 32'd1);
    check("lu_zero_ctrl",  32'(bus.ex_control), 32'b110);

    // Stall holds for three cycles while ID changes underneath.
    drive(1'b1, 2'b01, 6'h00, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    data(32'h1234, 32'h5678, 32'h9);
    tick();
    drive(1'b1, 2'b11, 6'h00, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    data(32'h9999, 32'h8888, 32'h7777);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_A", i),     bus.ex_A, 32'h1234);
      check($sformatf("stall%0d_ctrl", i),  32'(bus.ex_control), 32'b110);
      check($sformatf("stall%0d_valid", i), 32'(bus.ex_valid), 32'd1);
    end
    bus.flush = 1'b1;
    tick();
    check("flush_stall_valid", 32'(bus.ex_valid), 32'd0);
    check("flush_stall_A",     bus.ex_A, 32'd0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // Stall together with a load-use hazard: hold, then bubble on release.
    drive(1'b1, 2'b00, 6'h00, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    data(32'h100, 32'h200, 32'h4);
    tick();
    drive(1'b1, 2'b10, 6'h25, 5'd3, 5'd8, 5'd13, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.stall = 1'b1;
    #1;
    check("slu_assert", 32'(bus.load_use_stall), 32'd1);
    tick();
    check("slu_hold_memrd", 32'(bus.ex_mem_read), 32'd1);
    check("slu_hold_lu",    32'(bus.load_use_stall), 32'd1);
    check("slu_hold_A",     bus.ex_A, 32'h100);
    bus.stall = 1'b0;
    tick();
    check("slu_bubble_valid", 32'(bus.ex_valid), 32'd0);
    tick();
    check("slu_load_ctrl", 32'(bus.ex_control), 32'b001);
    check("slu_load_wreg", 32'(bus.ex_write_reg), 32'd13);

    // Reset during a pending load-use hazard, with stall also high.
    drive(1'b1, 2'b00, 6'h00, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 2'b10, 6'h20, 5'd8, 5'd1, 5'd14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("mrst_pre_valid", 32'(bus.ex_valid), 32'd1);
    check("mrst_pre_lu",    32'(bus.load_use_stall), 32'd1);
    reset     = 1'b1;
    bus.stall = 1'b1;
    #1;
    check("mrst_lu_comb", 32'(bus.load_use_stall), 32'd0);
    tick();
    check("mrst_valid", 32'(bus.ex_valid), 32'd0);
    check("mrst_memrd", 32'(bus.ex_mem_read), 32'd0);
    check("mrst_A",     bus.ex_A, 32'd0);
    check("mrst_rt",    32'(bus.ex_rt), 32'd0);
    check("mrst_lu",    32'(bus.load_use_stall), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/id_ex_issue.md
Name: id_ex_issue

Overview:
- Registered ID/EX boundary of the MIPS pipeline. It is the producer side of the Execute-stage ALU interface.
- Latches decode-stage operands and controls each cycle.
- Translates ALUOp/funct into the 3-bit ALU control code.
- Drives the ALU's A, a, b, sel and control inputs.
- Handles external stall, branch flush, and load-use bubble insertion.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold all EX registers (downstream stall).
- flush  in  1  squash the instruction entering EX (taken branch/jump).
- id_valid  in  1  decode slot holds a real instruction.
- id_rd1  in  DW  register-file read port 1 (rs value).
- id_rd2  in  DW  register-file read port 2 (rt value).
- id_imm  in  DW  sign-extended immediate.
- id_rs, id_rt, id_rd  in  RW  register indices.
- id_alu_op  in  2  main-decoder ALUOp.
- id_funct  in  6  instruction funct field.
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  main-decoder controls.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_A  out  DW  ALU first operand.
- ex_a  out  DW  ALU mux input a (rt value).
- ex_b  out  DW  ALU mux input b (immediate).
- ex_sel  out  1  ALU mux select (registered id_alu_src; 1 = immediate).
- ex_control  out  3  ALU control code.
- ex_write_reg  out  RW  destination: id_rd if id_reg_dst, else id_rt.
- ex_rs, ex_rt  out  RW  source indices for forwarding.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  forwarded controls.
- ex_illegal  out  1  unsupported funct under ALUOp=10.
- load_use_stall  out  1  request to hold PC and IF/ID this cycle.

Behaviour:
- All state updates on rising clk only. Latency ID->EX is 1 cycle.
- ALU control decode:
  - ALUOp 00 -> 010 (add).
  - ALUOp 01 -> 110 (sub).
  - ALUOp 11 -> 001 (or, ori).
  - ALUOp 10 uses funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct under ALUOp 10 -> 010 with illegal=1. Illegal is otherwise 0.
- load_use_stall is combinational from registered state plus ID inputs: ex_valid & ex_mem_read & id_valid & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt). It is 0 during reset.
- Next-state priority, highest first:
  1. reset: all outputs 0, including ex_control = 000 and ex_valid = 0.
  2. flush: load a bubble.
  3. stall: hold every register unchanged, including ex_valid.
  4. load_use_stall = 1: load a bubble.
  5. Otherwise: load the decode-slot values.
- Bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal = 0. All data/index fields = 0 and ex_control = 000.
- Load when id_valid = 0: identical to a bubble.
- Load when id_valid = 1: all fields latched from ID and decoded values. ex_valid = 1.
- Simultaneous cases:
  - flush + stall: flush wins; the bubble overwrites the held instruction.
  - stall + load_use: hold. load_use_stall stays asserted, and the bubble is inserted on the first non-stalled edge.
- A load-use bubble lasts exactly one cycle. After the bubble, ex_mem_read = 0, so load_use_stall deasserts and the held ID instruction loads on the next edge.
- Reset asserted mid-stall or mid-bubble clears state on the next edge regardless of other inputs.
- Data fields are pass-through. No width change or arithmetic on operands.

Test Plan:
- Reset: assert reset with all id_* = 1 for 2 cycles -> all outputs 0 and ex_control = 000. Deassert -> first valid load appears 1 cycle later.
- Decode sweep: ALUOp = 10 with funct 20h/22h/24h/25h/2Ah -> ex_control = 010/110/000/001/111, ex_illegal = 0. funct = 27h -> ex_control = 010, ex_illegal = 1. ALUOp 00/01/11 -> 010/110/001.
- Operand pass: id_rd1 = 0x0000_0005, id_rd2 = 0xFFFF_FFFF, id_imm = 0x0000_0010, alu_src = 1, reg_dst = 0, id_rt = 9 -> ex_A = 5, ex_a = FFFF_FFFF, ex_b = 10, ex_sel = 1, ex_write_reg = 9.
- Load-use: lw into rt = 8, then an instruction with id_rs = 8 -> load_use_stall = 1 for 1 cycle, next EX is a bubble (ex_valid = 0), then the add loads. Repeat with rt = 0 -> no stall.
- Stall/flush: stall = 1 for 3 cycles -> outputs constant. Assert flush together with stall -> bubble next edge. stall + load_use -> hold, then bubble on release.
- Reset mid-operation: assert reset while ex_valid = 1 and load_use_stall = 1 -> next edge all outputs 0 and load_use_stall = 0.
